// File: rtl/reorder_ingress_ctl_pkg.sv
// rtl/reorder_ingress_ctl_pkg.sv - shared types and helpers for the reorder ingress steering stage
package reorder_pkg;

  typedef enum logic [1:0] {
    BK_FILL  = 2'd0,
    BK_FULL  = 2'd1,
    BK_DRAIN = 2'd2
  } bank_state_e;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  function automatic int depth_f(input int aw);
    return 2 ** aw;
  endfunction

endpackage

// File: rtl/reorder_ingress_ctl_if.sv
// rtl/reorder_ingress_ctl_if.sv - upstream beat handshake plus bank A/B write and drain-select bus
interface reorder_ingress_ctl_if #(
  parameter int DW = 18,
  parameter int AW = 7
);
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_data;
  logic [AW:0]   in_seq;

  logic          push_a;
  logic [DW-1:0] data_a;
  logic [AW-1:0] offset_a;
  logic          full_a;
  logic          empty_a;

  logic          push_b;
  logic [DW-1:0] data_b;
  logic [AW-1:0] offset_b;
  logic          full_b;
  logic          empty_b;

  logic          drain_sel;
  logic          err_dup;

  modport master (
    output in_vld, in_data, in_seq, full_a, empty_a, full_b, empty_b,
    input  in_rdy, push_a, data_a, offset_a, push_b, data_b, offset_b, drain_sel, err_dup
  );

  modport slave (
    input  in_vld, in_data, in_seq, full_a, empty_a, full_b, empty_b,
    output in_rdy, push_a, data_a, offset_a, push_b, data_b, offset_b, drain_sel, err_dup
  );
endinterface

// File: rtl/reorder_ingress_ctl_bank.sv
// rtl/reorder_ingress_ctl_bank.sv - one bank: fill/full/drain FSM, beat count, push register
// Optional duplicate-offset bitmap when REORDER_DUP_CHECK_EN is defined.
module reorder_bank_ctl
  import reorder_pkg::*;
#(
  parameter int DW = 18,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] wr_offset,
  input  logic          full,
  input  logic          empty,
  input  logic          drain_me,
  output logic          is_fill,
  output logic          leave_drain,
  output logic          push,
  output logic [DW-1:0] data,
  output logic [AW-1:0] offset,
  output logic          dup
);
  localparam int          DEPTH   = depth_f(AW);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  bank_state_e state, state_nxt;
  logic [AW:0] count, count_nxt;
  logic        drop;
  logic        take;

`ifdef REORDER_DUP_CHECK_EN
  logic [DEPTH-1:0] bitmap;

  // A repeated offset is still handshaken upstream so the stream never wedges on it.
  assign drop = accept && bitmap[wr_offset];

  always_ff @(posedge clk) begin
    if (rst || leave_drain) begin
      bitmap <= '0;
    end else if (take) begin
      bitmap[wr_offset] <= 1'b1;
    end
  end
`else
  assign drop = 1'b0;
`endif

  assign take        = accept && !drop;
  assign leave_drain = (state == BK_DRAIN) && empty;
  assign is_fill     = (state == BK_FILL);

  always_comb begin
    count_nxt = count;
    state_nxt = state;
    if (leave_drain) begin
      count_nxt = '0;
    end else if (take && count != DEPTH_C) begin
      count_nxt = count + 1'b1;
    end
    case (state)
      BK_FILL:  if (count_nxt == DEPTH_C) state_nxt = BK_FULL;
      BK_FULL:  if (full && drain_me)     state_nxt = BK_DRAIN;
      BK_DRAIN: if (empty)                state_nxt = BK_FILL;
      default:                            state_nxt = BK_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BK_FILL;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      push   <= 1'b0;
      dup    <= 1'b0;
      data   <= '0;
      offset <= '0;
    end else begin
      push <= take;
      dup  <= drop;
      if (take) begin
        data   <= wr_data;
        offset <= wr_offset;
      end
    end
  end

endmodule

// File: rtl/reorder_ingress_ctl.sv
// rtl/reorder_ingress_ctl.sv - steers sequence-tagged beats into reorder banks A/B and picks the drain bank
// Duplicate-offset dropping is enabled by REORDER_DUP_CHECK_EN (see reorder_bank_ctl).
module reorder_ingress_ctl
  import reorder_pkg::*;
#(
  parameter int DW = 18,
  parameter int AW = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  reorder_ingress_ctl_if.slave  bus
);
  logic  fill_a, fill_b;
  logic  leave_a, leave_b;
  logic  dup_a, dup_b;
  logic  xfer, accept_a, accept_b;
  bank_e in_bank;

  assign in_bank  = bank_e'(bus.in_seq[AW]);
  // Ready looks only at registered bank state; a bank reopening becomes usable next cycle.
  assign bus.in_rdy = !rst && ((in_bank == BANK_B) ? fill_b : fill_a);
  assign xfer     = bus.in_vld && bus.in_rdy;
  assign accept_a = xfer && (in_bank == BANK_A);
  assign accept_b = xfer && (in_bank == BANK_B);

  reorder_bank_ctl #(.DW(DW), .AW(AW)) u_bank_a (
    .clk         (clk),
    .rst         (rst),
    .accept      (accept_a),
    .wr_data     (bus.in_data),
    .wr_offset   (bus.in_seq[AW-1:0]),
    .full        (bus.full_a),
    .empty       (bus.empty_a),
    .drain_me    (bus.drain_sel == BANK_A),
    .is_fill     (fill_a),
    .leave_drain (leave_a),
    .push        (bus.push_a),
    .data        (bus.data_a),
    .offset      (bus.offset_a),
    .dup         (dup_a)
  );

  reorder_bank_ctl #(.DW(DW), .AW(AW)) u_bank_b (
    .clk         (clk),
    .rst         (rst),
    .accept      (accept_b),
    .wr_data     (bus.in_data),
    .wr_offset   (bus.in_seq[AW-1:0]),
    .full        (bus.full_b),
    .empty       (bus.empty_b),
    .drain_me    (bus.drain_sel == BANK_B),
    .is_fill     (fill_b),
    .leave_drain (leave_b),
    .push        (bus.push_b),
    .data        (bus.data_b),
    .offset      (bus.offset_b),
    .dup         (dup_b)
  );

  assign bus.err_dup = dup_a || dup_b;

  // Strict ping-pong: only the currently selected bank finishing its drain hands over.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.drain_sel <= 1'b0;
    end else if (bus.drain_sel ? leave_b : leave_a) begin
      bus.drain_sel <= ~bus.drain_sel;
    end
  end

endmodule
